water_supply_scheduler: RTL and testbench

//  Sequential scheduler for the tank's water-supply valve. It opens the valve when the

---
 rtl/water_supply_scheduler_pkg.sv | 18 +
 rtl/water_supply_scheduler_tick_timer.sv | 37 +++
 rtl/water_supply_scheduler.sv | 110 +++++++++++
 tb/tb_water_supply_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/water_supply_scheduler_pkg.sv
// Shared definitions for the water-supply valve scheduler: state encoding
// (also decoded by the display/debug blocks) and timer sizing helper.
package water_supply_scheduler_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_FILLING  = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/water_supply_scheduler_tick_timer.sv
// Tick-enabled up-counter with synchronous clear and a terminal-count compare.
// tc_hit flags the tick that would advance the count past tc_val.
module water_supply_scheduler_tick_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] tc_val,
  output logic         tc_hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && tick) begin
      count_d = count_q + W'(1);
    end
  end

  assign tc_hit = en && tick && (count_q == tc_val);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/water_supply_scheduler.sv
// Valve fill scheduler: opens at low mark, closes at high mark, enforces a
// minimum off-time between fills and latches a fault on a fill timeout.
module water_supply_scheduler
  import water_supply_scheduler_pkg::*;
#(
  parameter int unsigned MIN_OFF_TICKS      = 3,
  parameter int unsigned FILL_TIMEOUT_TICKS = 10,
  parameter int unsigned COUNT_W            = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               low_water_level,
  input  logic               high_water_level,
  input  logic               water_sensors_conflicting,
  input  logic               clear_fault,
  output logic               valvule,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [COUNT_W-1:0] fill_cycles
);

  localparam int unsigned TW = $clog2(max_u(MIN_OFF_TICKS, FILL_TIMEOUT_TICKS)) + 1;

  state_e             state_q, state_d;
  logic               valvule_q, valvule_d;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] fill_cycles_q, fill_cycles_d;

  logic          timer_en;
  logic          timer_clr;
  logic          timer_tc;
  logic [TW-1:0] timer_tc_val;

  assign timer_en     = (state_q == ST_FILLING) || (state_q == ST_COOLDOWN);
  assign timer_clr    = (state_d != state_q);
  assign timer_tc_val = (state_q == ST_FILLING) ? TW'(FILL_TIMEOUT_TICKS - 1)
                                                : TW'(MIN_OFF_TICKS - 1);

  water_supply_scheduler_tick_timer #(
    .W (TW)
  ) u_tick_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick),
    .en      (timer_en),
    .clr     (timer_clr),
    .tc_val  (timer_tc_val),
    .tc_hit  (timer_tc)
  );

  always_comb begin
    state_d       = state_q;
    fill_cycles_d = fill_cycles_q;
    unique case (state_q)
      ST_IDLE: begin
        // low and high together is treated as inconsistent: never open
        if (low_water_level && !high_water_level && !water_sensors_conflicting) begin
          state_d = ST_FILLING;
        end
      end
      ST_FILLING: begin
        if (water_sensors_conflicting) begin
          state_d = ST_COOLDOWN;
        end else if (high_water_level) begin
          state_d = ST_COOLDOWN;
          if (fill_cycles_q != {COUNT_W{1'b1}}) begin
            fill_cycles_d = fill_cycles_q + COUNT_W'(1);
          end
        end else if (timer_tc) begin
          state_d = ST_FAULT;
        end
      end
      ST_COOLDOWN: begin
        if (timer_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (clear_fault && !water_sensors_conflicting) begin
          state_d = ST_COOLDOWN;
        end
      end
      default: state_d = ST_COOLDOWN;
    endcase
  end

  assign valvule_d = (state_d == ST_FILLING);
  assign fault_d   = (state_d == ST_FAULT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_COOLDOWN;
      valvule_q     <= 1'b0;
      fault_q       <= 1'b0;
      fill_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      valvule_q     <= valvule_d;
      fault_q       <= fault_d;
      fill_cycles_q <= fill_cycles_d;
    end
  end

  assign valvule     = valvule_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign fill_cycles = fill_cycles_q;

endmodule

// File: tb/tb_water_supply_scheduler.sv
// Bench for water_supply_scheduler: per-cycle vector table through a
// scoreboard queue, then tick-paced sequences for timing corner cases.
module tb_water_supply_scheduler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       low = 1'b0;
  logic       high = 1'b0;
  logic       conf = 1'b0;
  logic       clr = 1'b0;
  logic       valvule;
  logic       fault;
  logic [1:0] state;
  logic [1:0] fill_cycles;

  water_supply_scheduler #(
    .MIN_OFF_TICKS      (3),
    .FILL_TIMEOUT_TICKS (10),
    .COUNT_W            (2)
  ) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .tick                      (tick),
    .low_water_level           (low),
    .high_water_level          (high),
    .water_sensors_conflicting (conf),
    .clear_fault               (clr),
    .valvule                   (valvule),
    .fault                     (fault),
    .state                     (state),
    .fill_cycles               (fill_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rn, lo, hi, cf, cl, tk;
    logic [1:0] st;
    logic       v, f;
    logic [1:0] fc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  vec_t sb [$];

  int checks = 0;
  int errors = 0;
  int tph = 0;

  function automatic vec_t mk(input logic rn, lo, hi, cf, cl, tk,
                              input logic [1:0] st, input logic v, f,
                              input logic [1:0] fc);
    vec_t r;
    r = '{rn:rn, lo:lo, hi:hi, cf:cf, cl:cl, tk:tk, st:st, v:v, f:f, fc:fc};
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic rn, lo_i, hi_i, cf_i, cl_i, tk_i);
    reset_n = rn; low = lo_i; high = hi_i; conf = cf_i; clr = cl_i; tick = tk_i;
    @(posedge clock);
    #1;
  endtask

  // one clock with the 1-in-4 tick pattern
  task automatic tstep(input logic lo_i, hi_i, cf_i, output logic tk);
    tk  = (tph == 3);
    tph = (tph + 1) % 4;
    drive(1'b1, lo_i, hi_i, cf_i, 1'b0, tk);
  endtask

  task automatic wait_state(input logic [1:0] target, input logic lo_i,
                            input int maxc, input string name);
    int   n;
    logic tk;
    n = 0;
    while (state !== target && n < maxc) begin
      tstep(lo_i, 1'b0, 1'b0, tk);
      n++;
    end
    chk(name, state, target);
  endtask

  initial begin
    vec_t e;
    logic tk;
    int   nt, t3, rise, n, fc0;
    logic rose;

    //             rn lo hi cf cl tk  st v  f  fc
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 0, 0, 2, 0, 0, 1);
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[15] = mk(1, 0, 1, 1, 0, 0, 2, 0, 0, 1);
    vecs[16] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 1);
    vecs[18] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    vecs[19] = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[20] = mk(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      reset_n = vecs[i].rn; low = vecs[i].lo; high = vecs[i].hi;
      conf = vecs[i].cf; clr = vecs[i].cl; tick = vecs[i].tk;
      sb.push_back(vecs[i]);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d {st,v,f,fc}", i), {state, valvule, fault, fill_cycles},
          {e.st, e.v, e.f, e.fc});
    end

    // power-up off-time: valve opens one clock after the 3rd tick
    tph = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_hold_state", state, 2);
    chk("reset_hold_valve", valvule, 0);
    nt = 0; t3 = -1; rise = -1; rose = 1'b0;
    for (int s = 1; s <= 40 && !rose; s++) begin
      tstep(1'b1, 1'b0, 1'b0, tk);
      if (tk) begin
        nt++;
        if (nt == 3) t3 = s;
      end
      if (valvule === 1'b1) begin
        rose = 1'b1;
        rise = s;
      end
    end
    chk("powerup_valve_rose", rose, 1);
    chk("powerup_ticks_before_open", nt, 3);
    chk("powerup_open_latency", rise - t3, 1);

    // fill timeout: FAULT on exactly the 10th tick
    nt = 0; n = 0;
    while (nt < 10 && n < 100) begin
      tstep(1'b0, 1'b0, 1'b0, tk);
      n++;
      if (tk) begin
        nt++;
        if (nt == 9) chk("timeout_tick9_state", state, 1);
      end
    end
    chk("timeout_state", state, 3);
    chk("timeout_fault", fault, 1);
    chk("timeout_valve", valvule, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clear_with_conflict_state", state, 3);
    chk("clear_with_conflict_fault", fault, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_state", state, 2);
    chk("clear_fault_low", fault, 0);
    wait_state(2'd0, 1'b0, 20, "cooldown_after_clear");

    // high coinciding with the timeout tick: counted fill, no fault
    fc0 = fill_cycles;
    tstep(1'b1, 1'b0, 1'b0, tk);
    chk("coinc_enter_fill", state, 1);
    nt = 0; n = 0;
    while (nt < 9 && n < 100) begin
      tstep(1'b0, 1'b0, 1'b0, tk);
      n++;
      if (tk) nt++;
    end
    while (tph != 3 && n < 100) begin
      tstep(1'b0, 1'b0, 1'b0, tk);
      n++;
    end
    chk("coinc_still_filling", state, 1);
    tph = 0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("coinc_state", state, 2);
    chk("coinc_fault", fault, 0);
    chk("coinc_fill_count", fill_cycles, fc0 + 1);

    // saturation of the 2-bit fill counter, then reset mid-fill
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_reset_count", fill_cycles, 0);
    for (int i = 1; i <= 5; i++) begin
      wait_state(2'd0, 1'b0, 30, $sformatf("sat_idle%0d", i));
      tstep(1'b1, 1'b0, 1'b0, tk);
      chk($sformatf("sat_fill%0d_state", i), state, 1);
      tstep(1'b0, 1'b1, 1'b0, tk);
      chk($sformatf("sat_fill%0d_count", i), fill_cycles, (i > 3) ? 3 : i);
    end
    wait_state(2'd0, 1'b0, 30, "midfill_idle");
    tstep(1'b1, 1'b0, 1'b0, tk);
    chk("midfill_valve_open", valvule, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midfill_reset_valve", valvule, 0);
    chk("midfill_reset_state", state, 2);
    chk("midfill_reset_count", fill_cycles, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
